// File: rtl/cn_pkg.sv
// Shared types and constants for the CryptoNight main-loop datapath.
// Home of the swapped-lane 2x64 adder used after the scratchpad multiply.
package cn_pkg;

  localparam int ADDR_W   = 17;
  localparam int ITER_MAX = 524288;

  typedef logic [127:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } stage_state_e;

  // Each 64-bit lane wraps on its own; the product halves cross over.
  function automatic word_t lane_add64x2(input word_t a, input word_t p);
    lane_add64x2 = {a[127:64] + p[63:0], a[63:0] + p[127:64]};
  endfunction

endpackage

// File: rtl/mul_sum_xor_stage.sv
// Post-multiplier stage of the CryptoNight loop: waits out the multiplier latency,
// forms the swapped-lane sum with A, presents write-back and next A, counts iterations.
module mul_sum_xor_stage #(
  parameter int MULT_DELAY = 2,
  parameter int ADDR_W     = cn_pkg::ADDR_W,
  parameter int ITER_W     = 20,
  parameter int ITER_MAX   = cn_pkg::ITER_MAX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [127:0]      a_in,
  input  logic [127:0]      c_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [127:0]      product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [127:0]      wr_data,
  output logic [127:0]      next_a,
  output logic [ADDR_W-1:0] next_addr,
  output logic [ITER_W-1:0] iter_count,
  output logic              loop_done
);

  import cn_pkg::*;

  localparam logic [1:0]        DLY_LOAD = 2'(MULT_DELAY - 1);
  localparam logic [ITER_W-1:0] ITER_LIM = ITER_W'(ITER_MAX);

  stage_state_e      state_q, state_d;
  logic [1:0]        dly_q, dly_d;
  logic              latch, capture, handshake;
  word_t             a_q, c_q, sum;
  logic [ADDR_W-1:0] addr_q;

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    issue_ready = 1'b0;
    out_valid   = 1'b0;
    latch       = 1'b0;
    capture     = 1'b0;
    handshake   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) begin
          latch   = 1'b1;
          dly_d   = DLY_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dly_q != 2'd0) begin
          dly_d = dly_q - 2'd1;
        end else begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid   = 1'b1;
        issue_ready = out_ready;
        if (out_ready) begin
          handshake = 1'b1;
          if (issue_valid) begin
            latch   = 1'b1;
            dly_d   = DLY_LOAD;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sum       = lane_add64x2(a_q, product);
  assign next_addr = next_a[ADDR_W+3:4];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      a_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      next_a  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      if (latch) begin
        a_q    <= a_in;
        c_q    <= c_in;
        addr_q <= addr_in;
      end
      if (capture) begin
        wr_addr <= addr_q;
        wr_data <= sum;
        next_a  <= sum ^ c_q;
      end
    end
  end

  // start wins over a coincident handshake so a new run always begins at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iter_count <= '0;
      loop_done  <= 1'b0;
    end else if (start) begin
      iter_count <= '0;
      loop_done  <= 1'b0;
    end else if (handshake && iter_count != ITER_LIM) begin
      iter_count <= iter_count + 1'b1;
      if (iter_count == ITER_LIM - 1'b1) loop_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_sum_xor_stage.sv
// Scoreboarded bench: three stage instances (multiplier delay 1, 2, 3) share one
// stimulus stream; expected results are hand-computed vectors pushed on acceptance.
module tb_mul_sum_xor_stage;

  localparam int NI = 3;

  typedef struct {
    logic [127:0] a, c, p, data, na;
    logic [16:0]  addr, naddr;
  } vec_t;

  typedef struct {
    logic [127:0] data, na;
    logic [16:0]  addr, naddr;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         issue_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] a_in = '0, c_in = '0, p_bus = '0;
  logic [16:0]  addr_in = '0;
  logic [127:0] pipe [NI];

  logic         ir [NI], ov [NI], ld [NI];
  logic [16:0]  wa [NI], naddr [NI];
  logic [127:0] wd [NI], na [NI];
  logic [19:0]  ic [NI];

  vec_t tbl [5];
  int   vec_sel = 0;
  exp_t exp_q [NI][$];
  exp_t e;
  logic shown [NI];
  int   cnt [NI];
  logic done [NI];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    pipe[0] <= p_bus;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mul_sum_xor_stage #(
      .MULT_DELAY(g + 1),
      .ADDR_W    (17),
      .ITER_W    (20),
      .ITER_MAX  (4)
    ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .issue_valid(issue_valid),
      .issue_ready(ir[g]),
      .a_in       (a_in),
      .c_in       (c_in),
      .addr_in    (addr_in),
      .product    (pipe[g]),
      .out_valid  (ov[g]),
      .out_ready  (out_ready),
      .wr_addr    (wa[g]),
      .wr_data    (wd[g]),
      .next_a     (na[g]),
      .next_addr  (naddr[g]),
      .iter_count (ic[g]),
      .loop_done  (ld[g])
    );
  end

  task automatic checkOutput(input string name, input int idx,
                             input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got %h expected %h", name, idx, act, expv);
    end
  endtask

  // Monitor: compares presented results against the queue head, then models the counter.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NI; i++) begin
        exp_q[i].delete();
        shown[i] = 1'b0;
        cnt[i]   = 0;
        done[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        checkOutput("iter_count", i, 128'(ic[i]), 128'(cnt[i]));
        checkOutput("loop_done", i, 128'(ld[i]), 128'(done[i]));
        if (ov[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_out_valid dut%0d: got out_valid=1 expected 0", i);
          end else begin
            e = exp_q[i][0];
            if (!shown[i]) checkOutput("latency", i, 128'(cyc), 128'(e.cyc + i + 2));
            shown[i] = 1'b1;
            checkOutput("wr_addr", i, 128'(wa[i]), 128'(e.addr));
            checkOutput("wr_data", i, wd[i], e.data);
            checkOutput("next_a", i, na[i], e.na);
            checkOutput("next_addr", i, 128'(naddr[i]), 128'(e.naddr));
            checkOutput("issue_ready_hold", i, 128'(ir[i]), 128'(out_ready));
            if (out_ready) begin
              void'(exp_q[i].pop_front());
              shown[i] = 1'b0;
            end
          end
        end
        if (issue_valid && ir[i]) begin
          e.data  = tbl[vec_sel].data;
          e.na    = tbl[vec_sel].na;
          e.addr  = tbl[vec_sel].addr;
          e.naddr = tbl[vec_sel].naddr;
          e.cyc   = cyc;
          exp_q[i].push_back(e);
        end
        if (start) begin
          cnt[i]  = 0;
          done[i] = 1'b0;
        end else if (ov[i] && out_ready && cnt[i] != 4) begin
          cnt[i]++;
          if (cnt[i] == 4) done[i] = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input int idx);
    a_in        = tbl[idx].a;
    c_in        = tbl[idx].c;
    addr_in     = tbl[idx].addr;
    p_bus       = tbl[idx].p;
    vec_sel     = idx;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    a_in        = {$urandom, $urandom, $urandom, $urandom};
    c_in        = {$urandom, $urandom, $urandom, $urandom};
    p_bus       = {$urandom, $urandom, $urandom, $urandom};
    addr_in     = 17'($urandom);
  endtask

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int k = 0; k < 30 && !idle; k++) begin
      @(posedge clk);
      #2;
      idle = 1'b1;
      for (int i = 0; i < NI; i++)
        if (!ir[i] || ov[i] || exp_q[i].size() != 0) idle = 1'b0;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: got busy after 30 cycles expected idle");
    end
  endtask

  initial begin
    tbl[0] = '{a: '0, c: '0, p: {64'h1, 64'h2},
               data: {64'h2, 64'h1}, na: {64'h2, 64'h1},
               addr: 17'h00005, naddr: 17'h00000};
    tbl[1] = '{a: {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, c: '0,
               p: {64'h2, 64'h1},
               data: {64'h0, 64'h1}, na: {64'h0, 64'h1},
               addr: 17'h1FFFF, naddr: 17'h00000};
    tbl[2] = '{a: '0, c: 128'h0001_2340, p: '0,
               data: '0, na: 128'h0001_2340,
               addr: 17'h00000, naddr: 17'h01234};
    tbl[3] = '{a: {64'h1111_1111_1111_1111, 64'h8000_0000_0000_0000},
               c: {64'h0, 64'hFFFF_FFFF_FFFF_FFFF},
               p: {64'h8000_0000_0000_0000, 64'h2222_2222_2222_2222},
               data: {64'h3333_3333_3333_3333, 64'h0},
               na: {64'h3333_3333_3333_3333, 64'hFFFF_FFFF_FFFF_FFFF},
               addr: 17'h0ABCD, naddr: 17'h1FFFF};
    tbl[4] = '{a: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210},
               c: {64'hFFFF_FFFF_0000_0000, 64'h0000_0000_000A_5A50},
               p: {64'h1, 64'h1},
               data: {64'h0123_4567_89AB_CDF0, 64'hFEDC_BA98_7654_3211},
               na: {64'hFEDC_BA98_89AB_CDF0, 64'hFEDC_BA98_765E_6841},
               addr: 17'h13579, naddr: 17'h1E684};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput("rst_issue_ready", i, 128'(ir[i]), 128'd1);
      checkOutput("rst_out_valid", i, 128'(ov[i]), 128'd0);
      checkOutput("rst_wr_addr", i, 128'(wa[i]), 128'd0);
      checkOutput("rst_wr_data", i, wd[i], 128'd0);
      checkOutput("rst_next_a", i, na[i], 128'd0);
      checkOutput("rst_iter_count", i, 128'(ic[i]), 128'd0);
      checkOutput("rst_loop_done", i, 128'(ld[i]), 128'd0);
    end
    reset_n = 1'b1;

    // Five single iterations: the counter saturates at the overridden limit of 4.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(v);
      waitIdle();
    end

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Backpressure: result held, extra issue ignored, then back-to-back with start.
    out_ready = 1'b0;
    applyStimulus(0);
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(1);
    repeat (2) @(posedge clk);
    #1;
    start     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(2);
    start = 1'b0;
    waitIdle();

    // Reset while the multiply is in flight: nothing may come out.
    applyStimulus(3);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(4);
    waitIdle();

    for (int i = 0; i < NI; i++)
      checkOutput("queue_empty", i, 128'(exp_q[i].size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
